// File: rtl/disp_scan_ctrl.sv
// Multiplexed 8-digit BCD display scanner for a stopwatch.
// Lap capture/hold, leading-zero blanking, per-digit blink and PWM dimming.
module disp_scan_ctrl #(
  parameter int HOLD_FRAMES  = 200,
  parameter int BLINK_FRAMES = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_tick,
  input  logic [31:0] run_val,
  input  logic        lap_req,
  input  logic        lap_clr,
  input  logic [7:0]  blink_mask,
  input  logic [3:0]  bright,
  output logic [7:0]  an,
  output logic [3:0]  digit,
  output logic        mode,
  output logic        frame_start
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {RUN = 1'b0, LAP = 1'b1} state_t;

  state_t        state, state_nx;
  logic [2:0]    idx;
  logic [3:0]    pwm;
  logic [31:0]   snap;
  logic [31:0]   lap_reg;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          live;
  logic          wrap;
  logic [7:0]    zero_hi;
  logic          lit;

  assign wrap = scan_tick & (idx == 3'd7);

  // Source FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  // Source FSM: next state; clear beats capture, hold expiry ends lap
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: if (!lap_clr && lap_req) state_nx = LAP;
      LAP: begin
        if (lap_clr)
          state_nx = RUN;
        else if (lap_req)
          state_nx = LAP;
        else if (wrap && hold_cnt <= HW'(1))
          state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // Source FSM: output decode
  always_comb begin
    mode = (state == LAP);
  end

  // Lap capture register and frame-based hold countdown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_reg  <= '0;
      hold_cnt <= '0;
    end else if (lap_clr) begin
      hold_cnt <= '0;
    end else if (lap_req) begin
      lap_reg  <= run_val;
      hold_cnt <= HW'(HOLD_FRAMES);
    end else if (state == LAP && wrap && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // Scan index, PWM phase and frame snapshot; source latched only at wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx  <= '0;
      pwm  <= '0;
      snap <= '0;
      live <= 1'b0;
    end else begin
      idx  <= idx + {2'b00, scan_tick};
      pwm  <= pwm + 4'd1;
      live <= live | scan_tick;
      if (wrap) snap <= mode ? lap_reg : run_val;
    end
  end

  // Blink phase flips every BLINK_FRAMES frame wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // zero_hi[i]: snap nibble i and all above it are zero
  always_comb begin
    zero_hi    = '0;
    zero_hi[7] = (snap[31:28] == 4'd0);
    for (int i = 6; i >= 0; i--)
      zero_hi[i] = zero_hi[i+1] && (snap[4*i +: 4] == 4'd0);
  end

  // Lit decision for the currently selected digit
  always_comb begin
    lit = live
        && (idx == 3'd0 || !zero_hi[idx])
        && !(blink_mask[idx] && !blink_ph)
        && (bright == 4'hF || pwm < bright);
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an          <= 8'hFF;
      digit       <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      an          <= lit ? ~(8'b1 << idx) : 8'hFF;
      digit       <= snap[{idx, 2'b00} +: 4];
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with a frame-level reference model
// compared on every clock, plus hand-computed literal checks.
module tb_disp_scan_ctrl;

  localparam int HF = 2;
  localparam int BF = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_tick;
  logic [31:0] run_val;
  logic        lap_req;
  logic        lap_clr;
  logic [7:0]  blink_mask;
  logic [3:0]  bright;
  logic [7:0]  an;
  logic [3:0]  digit;
  logic        mode;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  disp_scan_ctrl #(.HOLD_FRAMES(HF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick),
    .run_val(run_val), .lap_req(lap_req), .lap_clr(lap_clr),
    .blink_mask(blink_mask), .bright(bright), .an(an),
    .digit(digit), .mode(mode), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames, lap hold and blink expressed as counts
  int          m_idx, m_wraps, m_cyc, m_ticks, m_left;
  logic [31:0] m_frame, m_lap;
  logic        m_mode;
  logic [7:0]  e_an;
  logic [3:0]  e_dig;
  logic        e_mode, e_fs;
  bit          m_ok = 0;

  always @(posedge clk) begin
    bit w, ph_on, l;
    if (!rst_n) begin
      m_idx = 0; m_wraps = 0; m_cyc = 0; m_ticks = 0; m_left = 0;
      m_frame = 0; m_lap = 0; m_mode = 0;
      e_an = 8'hFF; e_dig = 0; e_mode = 0; e_fs = 0;
    end else begin
      w     = scan_tick && m_idx == 7;
      ph_on = ((m_wraps / BF) % 2) == 0;
      l = m_ticks > 0
        && (m_idx == 0 || (m_frame >> (4 * m_idx)) != 0)
        && !(blink_mask[m_idx] && !ph_on)
        && (bright == 15 || (m_cyc % 16) < bright);
      e_an  = l ? (8'hFF ^ (8'd1 << m_idx)) : 8'hFF;
      e_dig = 4'((m_frame >> (4 * m_idx)) & 32'hF);
      e_fs  = w;
      if (w) begin
        m_frame = m_mode ? m_lap : run_val;
        m_wraps++;
      end
      if (lap_clr) begin
        m_mode = 0; m_left = 0;
      end else if (lap_req) begin
        m_mode = 1; m_lap = run_val; m_left = HF;
      end else if (m_mode && w) begin
        if (m_left > 0) m_left--;
        if (m_left == 0) m_mode = 0;
      end
      e_mode  = m_mode;
      m_idx   = (m_idx + int'(scan_tick)) % 8;
      m_cyc++;
      m_ticks += int'(scan_tick);
    end
    m_ok = 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("an", 32'(an), 32'(e_an));
      chk("digit", 32'(digit), 32'(e_dig));
      chk("mode", 32'(mode), 32'(e_mode));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  task automatic tk();
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame(output logic [31:0] seen, output logic [7:0] litm);
    seen = '0;
    litm = '0;
    for (int i = 0; i < 8; i++) begin
      tk();
      seen[4*i +: 4] = digit;
      litm[i] = (an != 8'hFF);
    end
  endtask

  logic [3:0]  exp_d [8];
  logic [7:0]  exp_a [8];
  logic [31:0] seen;
  logic [7:0]  la, lb;
  int          cnt;

  initial begin
    exp_d = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    exp_a = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
    rst_n = 0; scan_tick = 0; run_val = 0; lap_req = 0; lap_clr = 0;
    blink_mask = 0; bright = 4'd15;
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(an), 32'hFF);
    chk("reset_mode", 32'(mode), 32'd0);
    run_val = 32'h0001_2345;
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("no_lit_before_tick", 32'(an), 32'hFF);

    for (int i = 0; i < 8; i++) tk();
    chk("s1_digit0", 32'(digit), 32'(exp_d[0]));
    chk("s1_an0", 32'(an), 32'(exp_a[0]));
    for (int i = 1; i < 8; i++) begin
      tk();
      chk("s1_digit", 32'(digit), 32'(exp_d[i]));
      chk("s1_an", 32'(an), 32'(exp_a[i]));
    end

    run_val = 32'h0000_0730;
    lap_req = 1;
    @(negedge clk);
    lap_req = 0;
    run_val = 32'h0000_0999;
    chk("s2_mode_lap", 32'(mode), 32'd1);
    frame(seen, la);
    chk("s2_frame1", seen, 32'h0000_0730);
    chk("s2_mode_f1", 32'(mode), 32'd1);
    frame(seen, la);
    chk("s2_frame2", seen, 32'h0000_0730);
    chk("s2_mode_run", 32'(mode), 32'd0);
    frame(seen, la);
    chk("s2_frame3", seen, 32'h0000_0999);

    run_val = 32'h0000_1234;
    lap_req = 1; lap_clr = 1;
    @(negedge clk);
    lap_req = 0; lap_clr = 0;
    chk("s3_mode", 32'(mode), 32'd0);
    chk("s3_lap_reg", dut.lap_reg, 32'h0000_0730);

    blink_mask = 8'h03;
    frame(seen, la);
    frame(seen, lb);
    chk("s4_blink_diff", 32'(la ^ lb), 32'h03);
    chk("s4_blink_union", 32'(la | lb), 32'h0F);

    blink_mask = 8'h00;
    tk();
    bright = 4'd4;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an == 8'hFE) cnt++;
    end
    chk("s5_duty4", 32'(cnt), 32'd4);
    bright = 4'd0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an != 8'hFF) cnt++;
    end
    chk("s5_dark", 32'(cnt), 32'd0);

    bright = 4'd15;
    lap_req = 1;
    @(negedge clk);
    lap_req = 0;
    for (int i = 0; i < 5; i++) tk();
    chk("s6_mode_lap", 32'(mode), 32'd1);
    chk("s6_idx5", 32'(dut.idx), 32'd5);
    rst_n = 0;
    @(negedge clk);
    chk("s6_an", 32'(an), 32'hFF);
    chk("s6_mode", 32'(mode), 32'd0);
    chk("s6_idx", 32'(dut.idx), 32'd0);
    chk("s6_lap_reg", dut.lap_reg, 32'd0);
    chk("s6_digit", 32'(digit), 32'd0);
    rst_n = 1;
    run_val = 32'h0000_1234;
    repeat (4) @(negedge clk);
    chk("s6_dark_idle", 32'(an), 32'hFF);
    for (int i = 0; i < 8; i++) tk();
    chk("s6_first_frame_an", 32'(an), 32'hFE);
    chk("s6_first_frame_dig", 32'(digit), 32'd4);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- HOLD_FRAMES, 200, number of frames the lap value stays on the display.
- BLINK_FRAMES, 50, number of frames per blink half-period.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock for all logic.
- rst_n, in, 1, synchronous reset, active-low.
- scan_tick, in, 1, one-clk pulse that advances the scan by one digit.
- run_val, in, 32, live stopwatch time as 8 BCD nibbles; nibble 7 is the MSD.
- lap_req, in, 1, one-clk pulse that captures run_val and shows it.
- lap_clr, in, 1, one-clk pulse that returns the display to run_val.
- blink_mask, in, 8, per-digit blink enable; bit i controls digit i.
- bright, in, 4, brightness duty setting.
- an, out, 8, active-low one-hot digit select.
- digit, out, 4, BCD value of the selected digit.
- mode, out, 1, display source: 0 = run, 1 = lap.
- frame_start, out, 1, one-clk pulse when the scan wraps to digit 0.
REQ-003 All outputs SHALL be registered, and all state SHALL change only on the rising edge of clk.

Function
REQ-004 A 3-bit scan index idx SHALL increment modulo 8 on each cycle with scan_tick=1, and SHALL hold otherwise.
REQ-005 On the scan_tick that wraps idx from 7 to 0:
- frame_start SHALL be 1 for the following cycle.
- snap SHALL load the currently selected source: run_val when mode=0, lap_reg when mode=1.
REQ-006 digit SHALL equal snap[4*idx+3:4*idx], and SHALL update 1 clk after idx changes.
REQ-007 Display source FSM states are RUN (mode=0) and LAP (mode=1).
- RUN->LAP on lap_req: lap_reg<=run_val in the same edge, and hold_cnt<=HOLD_FRAMES.
- In LAP, lap_req again SHALL recapture lap_reg and reload hold_cnt to HOLD_FRAMES.
- In LAP, hold_cnt SHALL decrement on each frame wrap; when it reaches 0 the state SHALL return to RUN.
- lap_clr in any state SHALL force RUN on the next edge.
- If lap_req and lap_clr arrive in the same cycle, lap_clr wins and lap_reg is unchanged.
REQ-008 A mode change SHALL become visible on digit only from the next frame wrap; a frame is never mixed between sources.
REQ-009 Leading-zero blanking: digit i (i = 7..1) SHALL be dark when snap nibble i and every higher nibble are 0. Digit 0 SHALL never be blanked by this rule.
REQ-010 Blink:
- blink_ph SHALL toggle every BLINK_FRAMES frame wraps, and SHALL start at 1 (on).
- Digit i SHALL be dark while blink_mask[i]=1 and blink_ph=0.
REQ-011 Brightness:
- A 4-bit counter pwm SHALL free-run every clk, 0..15 with wrap.
- A digit is lit when pwm < bright, or when bright = 15.
- bright = 0 SHALL keep the display dark.
REQ-012 an SHALL drive 0 on bit idx only when that digit is lit per REQ-009..011; all other bits SHALL be 1.
REQ-013 Nibbles with values 10..15 SHALL pass through to digit unchanged and are never treated as zero for blanking.
REQ-014 hold_cnt SHALL be ceil(log2(HOLD_FRAMES+1)) bits wide and SHALL never wrap below 0.

Reset
REQ-015 While rst_n=0 at a clk edge, the block SHALL set:
- idx=0, pwm=0, snap=0, lap_reg=0, hold_cnt=0.
- State RUN, blink_ph=1.
- an=8'hFF, digit=0, mode=0, frame_start=0.
REQ-016 Reset asserted in the middle of a frame or during LAP SHALL abort immediately, with no pending lap or blink state kept.
REQ-017 After rst_n rises, the first lit output SHALL occur no earlier than the first scan_tick.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- run_val=32'h0001_2345, bright=15, 8 ticks -> digits 5,4,3,2,1 shown; an bits 7..5 stay 1; digit 0 an=8'hFE.
- lap_req at run_val=32'h0000_0730 with HOLD_FRAMES=2, then run_val=32'h0000_0999 -> mode=1, 2 frames show 0730, then mode=0 and frames show 0999.
- lap_req and lap_clr in the same cycle while in RUN -> mode stays 0 and lap_reg stays at its prior value.
- blink_mask=8'h03, BLINK_FRAMES=1 -> digits 0 and 1 are dark on alternate frames; other digits are unaffected.
- bright=4 -> an active-low for exactly 4 of every 16 clks on the selected digit; bright=0 -> an=8'hFF throughout.
- rst_n=0 during LAP at idx=5 -> next edge gives an=8'hFF, mode=0, idx=0, and lap_reg=0.
